uart_loopback_checker: RTL and testbench
========================================

# uart_loopback_checker

Traffic initiator and checker for the far end of the UART echo link. It drives a byte pattern into `uart_core`'s transmit handshake and waits for each byte to return on the receive side. It compares every echoed byte against the byte it sent and reports a pass/fail verdict with error counts. It sits beside `uart_core` in board-level self-test tops that talk to a remote echo target, such as a second board running RX-to-TX loopback.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 20000: cycles to wait for each echo; must be ≥ 1 and < 2^20. At 115200 baud on a 50 MHz clock, one round trip is about 8700 cycles.

Ports:
- `clk` in 1: single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request that begins a run.
- `num_bytes` in 16: number of bytes in the run; sampled on accepted `start`.
- `seed` in 8: first pattern byte; sampled on accepted `start`.
- `tx_valid` out 1: byte offered to `uart_core`.
- `tx_data` out 8: byte being offered.
- `tx_ready` in 1: `uart_core` accepts the offered byte.
- `rx_valid` in 1: one-cycle strobe that a received byte is present.
- `rx_data` in 8: received byte.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse at the end of a run.
- `pass` out 1: the last run had `err_cnt == 0`; held until the next accepted `start`.
- `err_cnt` out 16: mismatches plus timeouts in the current/last run; saturates at 0xFFFF.
- `timeout_cnt` out 16: timeouts only; saturates at 0xFFFF.
- `last_exp` out 8, `last_got` out 8: bytes from the most recent mismatch.

## Operation
- State machine: IDLE → SEND → WAIT → SEND … → DONE → IDLE.
- IDLE:
  - `start` is accepted here only; it is ignored in every other state.
  - On accept: latch `num_bytes` and `seed`, clear `err_cnt`, `timeout_cnt`, `last_exp`, `last_got` and `pass`, and set `busy`.
  - Go to DONE if `num_bytes == 0`, otherwise go to SEND.
- SEND:
  - `tx_valid = 1` and `tx_data = pattern`.
  - Both are held stable until a cycle with `tx_valid && tx_ready`, then go to WAIT with the timeout counter at 0.
  - `rx_valid` is ignored here.
- WAIT:
  - The first `rx_valid` ends the wait.
  - If `rx_data == pattern`, it is a match.
  - If not, increment `err_cnt` and record `last_exp = pattern`, `last_got = rx_data`.
  - If the timeout counter reaches `TIMEOUT_CYCLES - 1` with no `rx_valid`, increment `err_cnt` and `timeout_cnt`.
  - On either outcome: advance the pattern and increment the byte index. Go to DONE if the index equals the latched `num_bytes`, otherwise go to SEND.
- DONE: lasts exactly one cycle. `done = 1`, `pass = (err_cnt == 0)`, `busy` drops, next state IDLE.
- Pattern:
  - Byte 0 is `seed`.
  - Without `UART_CHK_LFSR_EN`: next byte = previous + 1, modulo 256 (wraps 0xFF → 0x00).
- Counters: the byte index and the latched count are 16 bits. `err_cnt` and `timeout_cnt` saturate and never wrap.

## Timing
- Reset values: `tx_valid`, `tx_data`, `busy`, `done`, `pass`, `err_cnt`, `timeout_cnt`, `last_exp`, `last_got` are all 0. State is IDLE.
- Accepted `start` in cycle N:
  - `busy = 1` and `tx_valid = 1` in cycle N+1.
  - When `num_bytes == 0`: `done` pulses in N+2 with `pass = 1`.
- A handshake in cycle M puts WAIT in M+1. A matching `rx_valid` in cycle K drives `tx_valid` again in K+1.
- Timeout fires exactly `TIMEOUT_CYCLES` cycles after entering WAIT when no `rx_valid` arrives.
- `rx_valid` in the same cycle the timeout expires counts as a received byte, not a timeout.
- Echoes that arrive late after a timeout land in a later WAIT. They are compared normally and will mismatch. This is intended and flags link slip.
- Asserting `rst` mid-run:
  - `tx_valid` drops immediately (asynchronous).
  - All outputs return to their reset values and no `done` is generated.

## Configuration
- `UART_CHK_LFSR_EN` defined:
  - Pattern is an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shift-left with feedback into bit 0.
  - `seed == 0x00` is replaced by `0x01`.
- Undefined: incrementing pattern only, and no LFSR logic is synthesized.

## Test plan
- Perfect echo model, 1-cycle `tx_ready`, `seed = 0xFE`, `num_bytes = 4` → sent bytes FE, FF, 00, 01; `done` pulses once; `pass = 1`; `err_cnt = 0`.
- Echo model that flips bit 0 of the third byte, `seed = 0x10`, `num_bytes = 5` → `err_cnt = 1`, `last_exp = 0x12`, `last_got = 0x13`, `pass = 0`.
- No echo, `TIMEOUT_CYCLES = 50`, `num_bytes = 2` → `done` arrives about 100 cycles after the handshakes; `err_cnt = 2`, `timeout_cnt = 2`.
- `tx_ready` held low for 30 cycles → `tx_valid`/`tx_data` stay stable throughout; `start` pulses while busy are ignored.
- `num_bytes = 0` → `done` in cycle N+2 with `pass = 1` and no `tx_valid`. Separately, asserting `rst` in WAIT → all outputs are 0 and the next `start` runs cleanly.
- With `UART_CHK_LFSR_EN` defined and `seed = 0x00`, run with a perfect echo model → first byte 0x01, and the following bytes match the reference LFSR sequence.

Source files
------------

// File: rtl/uart_loopback_checker.sv
// uart_loopback_checker
//   Traffic initiator / checker for a remote UART echo link. Offers a byte
//   pattern on the uart_core transmit handshake, waits for each byte to come
//   back on the receive strobe and scores mismatches and timeouts.
//
//   Optional feature macro: UART_CHK_LFSR_EN
//     defined   : pattern is an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1),
//                 seed 0x00 is replaced by 0x01
//     undefined : pattern increments by one per byte (mod 256)
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : one-cycle run request (accepted only when idle)
//   num_bytes, seed       : run length and first pattern byte, sampled on start
//   tx_valid/tx_data      : byte offered to uart_core
//   tx_ready              : uart_core accepts the offered byte
//   rx_valid/rx_data      : received byte strobe and data
//   busy                  : run in progress
//   done                  : one-cycle end-of-run pulse
//   pass                  : last run had no errors (held until next start)
//   err_cnt, timeout_cnt  : saturating error / timeout counters
//   last_exp, last_got    : expected / received bytes of the latest mismatch
module uart_loopback_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_bytes,
  input  logic [7:0]  seed,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic [15:0] timeout_cnt,
  output logic [7:0]  last_exp,
  output logic [7:0]  last_got
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  localparam logic [19:0] TMR_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  pattern;
  logic [7:0]  pat_next;
  logic [7:0]  seed_eff;
  logic [15:0] idx;
  logic [15:0] n_lat;
  logic [19:0] tmr;
  logic        rx_hit;
  logic        to_hit;
  logic        byte_end;
  logic        last_byte;

`ifdef UART_CHK_LFSR_EN
  always_comb begin
    pat_next = {pattern[6:0], pattern[7] ^ pattern[5] ^ pattern[4] ^ pattern[3]};
    seed_eff = (seed == 8'h00) ? 8'h01 : seed;
  end
`else
  always_comb begin
    pat_next = pattern + 8'd1;
    seed_eff = seed;
  end
`endif

  // A receive strobe on the final timeout cycle wins over the timeout.
  always_comb begin
    rx_hit    = (state == S_WAIT) && rx_valid;
    to_hit    = (state == S_WAIT) && !rx_valid && (tmr == TMR_LAST);
    byte_end  = rx_hit || to_hit;
    last_byte = (idx + 16'd1) == n_lat;
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = (state == S_SEND);
    tx_data   = (state == S_SEND) ? pattern : '0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (start) state_nxt = (num_bytes == 16'd0) ? S_DONE : S_SEND;
      S_SEND:  if (tx_ready) state_nxt = S_WAIT;
      S_WAIT:  if (byte_end) state_nxt = last_byte ? S_DONE : S_SEND;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // done/pass are registered out of S_DONE, so they appear the cycle after
  // the DONE state, together with busy dropping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pattern     <= '0;
      idx         <= '0;
      n_lat       <= '0;
      tmr         <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_cnt     <= '0;
      timeout_cnt <= '0;
      last_exp    <= '0;
      last_got    <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            n_lat       <= num_bytes;
            pattern     <= seed_eff;
            idx         <= '0;
            err_cnt     <= '0;
            timeout_cnt <= '0;
            last_exp    <= '0;
            last_got    <= '0;
            pass        <= 1'b0;
          end
        end
        S_SEND: begin
          if (tx_ready) tmr <= '0;
        end
        S_WAIT: begin
          if (rx_hit) begin
            if (rx_data != pattern) begin
              if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
              last_exp <= pattern;
              last_got <= rx_data;
            end
          end else if (to_hit) begin
            if (err_cnt != '1)     err_cnt     <= err_cnt + 16'd1;
            if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + 16'd1;
          end else begin
            tmr <= tmr + 20'd1;
          end
          if (byte_end) begin
            pattern <= pat_next;
            idx     <= idx + 16'd1;
          end
        end
        S_DONE: begin
          pass <= (err_cnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loopback_checker.sv
module tb_uart_loopback_checker;
  localparam int unsigned T = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_bytes;
  logic [7:0]  seed;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        busy, done, pass;
  logic [15:0] err_cnt, timeout_cnt;
  logic [7:0]  last_exp, last_got;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  uart_loopback_checker #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .start(start), .num_bytes(num_bytes), .seed(seed),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .timeout_cnt(timeout_cnt),
    .last_exp(last_exp), .last_got(last_got)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference pattern: byte i of a run started with seed s.
  function automatic logic [7:0] pat(input logic [7:0] s, input int unsigned i);
`ifdef UART_CHK_LFSR_EN
    logic [7:0] p;
    p = (s == 8'h00) ? 8'h01 : s;
    for (int unsigned k = 0; k < i; k++) p = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    return p;
`else
    return s + i[7:0];
`endif
  endfunction

  // cycle counter and tx_ready driver
  int unsigned cyc = 0;
  int unsigned stall_end = 0;
  bit          ready_rand = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cyc < stall_end)  tx_ready = 1'b0;
      else if (ready_rand)  tx_ready = 1'($urandom_range(0, 1));
      else                  tx_ready = 1'b1;
    end
  end

  // Echo target and error model: 0 perfect, 1 flip bit0 of byte flip_idx,
  // 2 no echo, 3 random mix of good / corrupt / missing echoes.
  int          echo_mode = 0;
  int unsigned flip_idx = 0;
  logic [7:0]  r_seed = 0;
  int unsigned resp_idx = 0;
  int unsigned exp_err = 0, exp_to = 0;
  logic [7:0]  exp_le = 0, exp_lg = 0;

  initial begin
    int kind;
    int unsigned d;
    logic [7:0] b, rd;
    rx_valid = 1'b0;
    rx_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (start && !busy) begin
        r_seed = seed; resp_idx = 0; exp_err = 0; exp_to = 0; exp_le = 0; exp_lg = 0;
      end else if (tx_valid && tx_ready) begin
        b = tx_data;
        case (echo_mode)
          1:       kind = (resp_idx == flip_idx) ? 1 : 0;
          2:       kind = 2;
          3:       kind = ($urandom_range(0, 3) == 0) ? 2 : ($urandom_range(0, 3) == 0) ? 1 : 0;
          default: kind = 0;
        endcase
        if (kind == 2) begin
          exp_err++; exp_to++;
        end else begin
          rd = b;
          if (kind == 1) begin
            rd = (echo_mode == 1) ? (b ^ 8'h01) : (b ^ 8'($urandom_range(1, 255)));
            exp_err++;
            exp_le = pat(r_seed, resp_idx);
            exp_lg = rd;
          end
          d = $urandom_range(1, T - 3);
          repeat (d) @(posedge clk);
          #1 rx_valid = 1'b1; rx_data = rd;
          @(posedge clk);
          #1 rx_valid = 1'b0;
        end
        resp_idx++;
      end
    end
  end

  // Per-cycle compare process
  logic [7:0]  c_seed = 0;
  int unsigned c_idx = 0, c_n = 0, done_cnt = 0;
  logic [7:0]  sent [0:63];

  initial begin
    bit stalled;
    logic [7:0] held;
    stalled = 0; held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin stalled = 0; continue; end
      if (start && !busy) begin
        c_idx = 0; c_seed = seed; c_n = num_bytes; stalled = 0;
      end
      if (stalled) begin
        chk("tx_hold_valid", 64'(tx_valid), 64'd1);
        chk("tx_hold_data", 64'(tx_data), 64'(held));
      end
      if (tx_valid) chk("tx_data", 64'(tx_data), 64'(pat(c_seed, c_idx)));
      stalled = tx_valid && !tx_ready;
      held = tx_data;
      if (tx_valid && tx_ready) begin
        sent[c_idx % 64] = tx_data;
        c_idx++;
      end
      if (done) begin
        done_cnt++;
        chk("done_bytes_sent", 64'(c_idx), 64'(c_n));
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_err_cnt", 64'(err_cnt), 64'(exp_err));
        chk("done_timeout_cnt", 64'(timeout_cnt), 64'(exp_to));
        chk("done_pass", 64'(pass), 64'(exp_err == 0));
        chk("done_last_exp", 64'(last_exp), 64'(exp_le));
        chk("done_last_got", 64'(last_got), 64'(exp_lg));
      end
    end
  end

  task automatic start_run(input logic [7:0] s, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; seed = s; num_bytes = n;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_tx_valid", 64'(tx_valid), 64'(n != 0));
  endtask

  task automatic wait_done(input int unsigned budget, output int unsigned lat);
    bit seen;
    seen = 0; lat = 1;
    while (!seen && lat <= budget) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin @(posedge clk); lat++; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout got no done within %0d cycles", budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic zero_outputs(input string name);
    chk(name, 64'({tx_valid, tx_data, busy, done, pass, err_cnt, timeout_cnt, last_exp, last_got}), 64'd0);
  endtask

  initial begin
    int unsigned lat, dc;
    rst = 1'b1; start = 1'b0; num_bytes = '0; seed = '0;
    repeat (3) @(posedge clk);
    #1 zero_outputs("reset_state");
    rst = 1'b0;

    // perfect echo with pattern wrap
    dc = done_cnt; echo_mode = 0;
    start_run(8'hFE, 16'd4);
    wait_done(4 * (T + 10) + 20, lat);
    chk("a_done_once", 64'(done_cnt), 64'(dc + 1));
    chk("a_pass", 64'(pass), 64'd1);
    chk("a_err", 64'(err_cnt), 64'd0);
`ifndef UART_CHK_LFSR_EN
    chk("a_byte0", 64'(sent[0]), 64'hFE);
    chk("a_byte1", 64'(sent[1]), 64'hFF);
    chk("a_byte2", 64'(sent[2]), 64'h00);
    chk("a_byte3", 64'(sent[3]), 64'h01);
`endif

    // third byte echoed with bit 0 flipped
    dc = done_cnt; echo_mode = 1; flip_idx = 2;
    start_run(8'h10, 16'd5);
    wait_done(5 * (T + 10) + 20, lat);
    chk("b_done_once", 64'(done_cnt), 64'(dc + 1));
    chk("b_err", 64'(err_cnt), 64'd1);
    chk("b_pass", 64'(pass), 64'd0);
`ifndef UART_CHK_LFSR_EN
    chk("b_last_exp", 64'(last_exp), 64'h12);
    chk("b_last_got", 64'(last_got), 64'h13);
`endif

    // no echo: two timeouts
    echo_mode = 2;
    start_run(8'h20, 16'd2);
    wait_done(200, lat);
    chk("c_latency", 64'(lat), 64'd104);
    chk("c_err", 64'(err_cnt), 64'd2);
    chk("c_timeouts", 64'(timeout_cnt), 64'd2);

    // tx_ready stalled for 30 cycles, start pulse while busy ignored
    dc = done_cnt; echo_mode = 0;
    stall_end = cyc + 32;
    start_run(8'($urandom), 16'd3);
    repeat (10) @(posedge clk);
    #1 start = 1'b1; num_bytes = 16'd0; seed = 8'h55;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("d_stall_valid", 64'(tx_valid), 64'd1);
    wait_done(3 * (T + 10) + 60, lat);
    chk("d_done_once", 64'(done_cnt), 64'(dc + 1));
    chk("d_pass", 64'(pass), 64'd1);

    // zero-length run
    dc = done_cnt;
    start_run(8'h33, 16'd0);
    wait_done(10, lat);
    chk("e_latency", 64'(lat), 64'd2);
    chk("e_pass", 64'(pass), 64'd1);
    chk("e_done_once", 64'(done_cnt), 64'(dc + 1));

    // reset while waiting for an echo
    dc = done_cnt; echo_mode = 2;
    start_run(8'h44, 16'd3);
    for (int i = 0; i < 20 && c_idx < 1; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 zero_outputs("f_reset_in_wait");
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("f_no_done", 64'(done_cnt), 64'(dc));
    dc = done_cnt; echo_mode = 0;
    start_run(8'h80, 16'd3);
    wait_done(3 * (T + 10) + 20, lat);
    chk("f_rerun_done", 64'(done_cnt), 64'(dc + 1));
    chk("f_rerun_pass", 64'(pass), 64'd1);

    // reset while offering a byte drops tx_valid at once
    stall_end = cyc + 100;
    start_run(8'h5A, 16'd2);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 zero_outputs("g_reset_in_send");
    @(posedge clk); #1 rst = 1'b0;
    stall_end = 0;

`ifdef UART_CHK_LFSR_EN
    echo_mode = 0;
    start_run(8'h00, 16'd8);
    wait_done(8 * (T + 10) + 20, lat);
    chk("l_byte0", 64'(sent[0]), 64'h01);
    chk("l_byte4", 64'(sent[4]), 64'h10);
    chk("l_byte5", 64'(sent[5]), 64'h21);
    chk("l_pass", 64'(pass), 64'd1);
`endif

    // randomized runs
    ready_rand = 1; echo_mode = 3;
    for (int r = 0; r < 10; r++) begin
      int unsigned n;
      n = $urandom_range(1, 10);
      dc = done_cnt;
      start_run(8'($urandom), 16'(n));
      wait_done(n * (T + 40) + 40, lat);
      chk("h_done_once", 64'(done_cnt), 64'(dc + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
